cpu_step_ctrl: RTL and testbench
================================

// Module: cpu_step_ctrl
// PURPOSE
//  Parametrised clock-enable controller for the pipelined MIPS demo. Debounces the step button and drives
//  one enable into the processor and data memory in one of three modes: single-step, N-step burst,
//  or divided free-run. The optional breakpoint halts on a PC match. Sits between the board inputs and mips/dmem.
// PARAMETERS
//  DEBOUNCE_CYCLES  50000  cycles the synchronised button must be stable before the debounced level changes
//  BURST_W          8      width of burst_len
//  DIV_W            24     width of run_div
//  CNT_W            16     width of step_count
//  PC_W             32     width of pc / bp_addr
// PORTS
//  clk        in   1        system clock
//  reset      in   1        synchronous, active-high reset
//  sw_step    in   1        raw, asynchronous step/start/stop button
//  mode       in   2        00 single-step, 01 burst, 10 free-run, 11 treated as 00
//  burst_len  in   BURST_W  enables issued per burst; 0 is treated as 1
//  run_div    in   DIV_W    free-run: one enable every run_div+1 cycles
//  pc         in   PC_W     current processor PC
//  bp_addr    in   PC_W     breakpoint address
//  bp_valid   in   1        breakpoint armed
//  cpu_en     out  1        one-cycle processor/dmem clock enable
//  busy       out  1        1 in BURST or RUN
//  halted     out  1        1 in HALT
//  step_count out  CNT_W    count of cpu_en pulses since reset; wraps
// BEHAVIOUR
//  - Reset: state IDLE; cpu_en=0, busy=0, halted=0, step_count=0.
//    Synchroniser, debounce counter and debounced level are all 0.
//    A button held through reset therefore yields a press DEBOUNCE_CYCLES after the synchronised level.
//  - Input path: 2-FF synchroniser, then debounce. A press is a 1-cycle pulse on a debounced 0->1 edge.
//    Raw edge to press: 2+DEBOUNCE_CYCLES+1 cycles. Releases generate nothing.
//  - mode, burst_len and run_div are sampled only on a press in IDLE. Later changes are ignored until IDLE.
//  - States: IDLE, BURST, RUN, HALT (single-step needs no state).
//    IDLE + press, mode 00/11: cpu_en=1 on the next cycle; stay in IDLE.
//    IDLE + press, mode 01: load remaining=max(burst_len,1); go to BURST.
//    IDLE + press, mode 10: load div=0; go to RUN.
//    BURST: cpu_en=1 every cycle, remaining decrements; at remaining==1 the last enable issues, then IDLE.
//    RUN: when div==0, cpu_en=1 and div reloads with run_div; otherwise div decrements.
//      run_div=0 gives cpu_en every cycle.
//    BURST/RUN + press: abort to IDLE the next cycle. No enable is issued in the press cycle.
//    HALT: cpu_en=0, halted=1. A press returns to IDLE with halted=0 and issues no enable.
//  - cpu_en is registered, so at most one enable is issued per clk. step_count increments in the same cycle cpu_en=1.
//  - Press and breakpoint hit in the same cycle: the press wins and the next state is IDLE.
// CONFIGURATION
//  - CPU_STEP_BREAKPOINT_EN defined:
//    In BURST/RUN, when an enable is due and bp_valid && pc==bp_addr, the enable is suppressed and the next state is HALT.
//    The first enable after leaving IDLE ignores the breakpoint, so a resume from the breakpoint PC works.
//    Single-step ignores the breakpoint.
//  - CPU_STEP_BREAKPOINT_EN undefined: the ports remain, pc/bp_addr/bp_valid are ignored, HALT is unreachable, halted=0.
// STRUCTURE
//  - Shared package cpu_step_pkg: mode encodings (MODE_STEP, MODE_BURST, MODE_RUN) and the state encoding localparams.
//  - One sub-module: btn_debounce (synchroniser + debounce counter + press-pulse output), parametrised by DEBOUNCE_CYCLES.
//  - Everything else is the FSM plus the remaining, div and step_count counters in cpu_step_ctrl.
// TESTING (DEBOUNCE_CYCLES=4)
//  1. mode=00, press and hold 20 cycles -> exactly one cpu_en pulse, 8 cycles after the raw edge; step_count=1.
//     A 2-cycle glitch produces no pulse.
//  2. mode=01, burst_len=5 -> 5 consecutive cpu_en cycles, then IDLE with busy=0; step_count=5.
//     With burst_len=0 -> exactly 1 enable.
//  3. mode=10, run_div=3 -> cpu_en every 4th cycle.
//     A second press -> IDLE and no further enables. With run_div=0 -> continuous enables.
//  4. BREAKPOINT_EN, mode=10, run_div=0, bp_valid=1, bp_addr=0x18, pc advancing by 4 per enable from 0
//     -> halts with pc=0x18 and halted=1, enable suppressed.
//     Press -> IDLE. Press again -> RUN resumes past 0x18.
//  5. Reset asserted mid-BURST (remaining=3) -> next cycle cpu_en=0, busy=0, step_count=0.
//     No enables until a new press.
//  6. step_count at 0xFFFF plus one enable -> wraps to 0x0000.
//     Without the macro, the scenario 4 stimulus runs with no halt.

Source files
------------

// File: rtl/cpu_step_pkg.sv
// Shared encodings for the MIPS demo step controller: button modes and FSM states.
package cpu_step_pkg;

  localparam logic [1:0] MODE_STEP  = 2'b00;
  localparam logic [1:0] MODE_BURST = 2'b01;
  localparam logic [1:0] MODE_RUN   = 2'b10;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StBurst = 2'b01,
    StRun   = 2'b10,
    StHalt  = 2'b11
  } state_e;

  // The unused encoding 2'b11 behaves as single-step.
  function automatic logic [1:0] decode_mode(input logic [1:0] mode);
    logic [1:0] m;
    unique case (mode)
      MODE_BURST: m = MODE_BURST;
      MODE_RUN:   m = MODE_RUN;
      default:    m = MODE_STEP;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser and debounce counter for a raw button; emits a one-cycle
// pulse on each debounced 0->1 transition. Releases produce no pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_press
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            r_sync1;
  logic            r_sync2;
  logic [CntW-1:0] r_cnt;
  logic            r_level;
  logic            r_level_prev;
  logic            r_press;
  logic            w_stable;

  assign w_stable = (r_sync2 == r_level);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync1      <= 1'b0;
      r_sync2      <= 1'b0;
      r_cnt        <= '0;
      r_level      <= 1'b0;
      r_level_prev <= 1'b0;
      r_press      <= 1'b0;
    end else begin
      r_sync1      <= i_btn;
      r_sync2      <= r_sync1;
      r_level_prev <= r_level;
      r_press      <= r_level & ~r_level_prev;
      // Any bounce back to the current level restarts the stability window.
      if (w_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CntLast) begin
        r_cnt   <= '0;
        r_level <= r_sync2;
      end else begin
        r_cnt <= r_cnt + CntW'(1);
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/cpu_step_ctrl.sv
// Clock-enable controller for the pipelined MIPS demo: single-step, N-step burst or divided
// free-run. Define CPU_STEP_BREAKPOINT_EN to halt BURST/RUN when pc matches bp_addr.
module cpu_step_ctrl
  import cpu_step_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned BURST_W         = 8,
  parameter int unsigned DIV_W           = 24,
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned PC_W            = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_sw_step,
  input  logic [1:0]         i_mode,
  input  logic [BURST_W-1:0] i_burst_len,
  input  logic [DIV_W-1:0]   i_run_div,
  input  logic [PC_W-1:0]    i_pc,
  input  logic [PC_W-1:0]    i_bp_addr,
  input  logic               i_bp_valid,
  output logic               o_cpu_en,
  output logic               o_busy,
  output logic               o_halted,
  output logic [CNT_W-1:0]   o_step_count
);

  state_e             r_state, w_state_d;
  logic [BURST_W-1:0] r_remaining, w_remaining_d;
  logic [DIV_W-1:0]   r_div, w_div_d;
  logic [DIV_W-1:0]   r_run_div, w_run_div_d;
  logic               r_first, w_first_d;
  logic               r_cpu_en, w_en_d;
  logic [CNT_W-1:0]   r_step_count;
  logic               w_press;
  logic               w_bp_hit;
  logic [1:0]         w_mode;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_btn  (i_sw_step),
    .o_press(w_press)
  );

  assign w_mode = decode_mode(i_mode);

`ifdef CPU_STEP_BREAKPOINT_EN
  // The first enable after leaving IDLE ignores the breakpoint so a resume can step off it.
  assign w_bp_hit = i_bp_valid && (i_pc == i_bp_addr) && !r_first;
`else
  logic w_unused_bp;
  assign w_unused_bp = ^{i_pc, i_bp_addr, i_bp_valid, r_first};
  assign w_bp_hit    = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= StIdle;
      r_remaining  <= '0;
      r_div        <= '0;
      r_run_div    <= '0;
      r_first      <= 1'b0;
      r_cpu_en     <= 1'b0;
      r_step_count <= '0;
    end else begin
      r_state      <= w_state_d;
      r_remaining  <= w_remaining_d;
      r_div        <= w_div_d;
      r_run_div    <= w_run_div_d;
      r_first      <= w_first_d;
      r_cpu_en     <= w_en_d;
      r_step_count <= r_step_count + CNT_W'(w_en_d);
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_remaining_d = r_remaining;
    w_div_d       = r_div;
    w_run_div_d   = r_run_div;
    w_first_d     = r_first;
    w_en_d        = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_press) begin
          unique case (w_mode)
            MODE_BURST: begin
              w_state_d     = StBurst;
              w_remaining_d = (i_burst_len == '0) ? BURST_W'(1) : i_burst_len;
              w_first_d     = 1'b1;
            end
            MODE_RUN: begin
              w_state_d   = StRun;
              w_div_d     = '0;
              w_run_div_d = i_run_div;
              w_first_d   = 1'b1;
            end
            default: w_en_d = 1'b1;
          endcase
        end
      end
      StBurst: begin
        if (w_press) begin
          w_state_d = StIdle;
        end else if (w_bp_hit) begin
          w_state_d = StHalt;
        end else begin
          w_en_d        = 1'b1;
          w_first_d     = 1'b0;
          w_remaining_d = r_remaining - BURST_W'(1);
          if (r_remaining == BURST_W'(1)) begin
            w_state_d = StIdle;
          end
        end
      end
      StRun: begin
        if (w_press) begin
          w_state_d = StIdle;
        end else if (r_div == '0) begin
          if (w_bp_hit) begin
            w_state_d = StHalt;
          end else begin
            w_en_d    = 1'b1;
            w_first_d = 1'b0;
            w_div_d   = r_run_div;
          end
        end else begin
          w_div_d = r_div - DIV_W'(1);
        end
      end
      StHalt: begin
        if (w_press) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    o_cpu_en = r_cpu_en;
    o_busy   = (r_state == StBurst) || (r_state == StRun);
    o_halted = (r_state == StHalt);
  end

  assign o_step_count = r_step_count;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl with DEBOUNCE_CYCLES=4; a scoreboard queue holds the
// cycle and step_count expected for every cpu_en pulse.
module tb_cpu_step_ctrl;

  localparam int unsigned DB = 4;
  localparam int unsigned BW = 8;
  localparam int unsigned DW = 24;
  localparam int unsigned CW = 16;
  localparam int unsigned PW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          sw_step;
  logic [1:0]    mode;
  logic [BW-1:0] burst_len;
  logic [DW-1:0] run_div;
  logic [PW-1:0] pc;
  logic [PW-1:0] bp_addr;
  logic          bp_valid;
  logic          cpu_en;
  logic          busy;
  logic          halted;
  logic [CW-1:0] step_count;

  always #5 clk = ~clk;

  cpu_step_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .BURST_W        (BW),
    .DIV_W          (DW),
    .CNT_W          (CW),
    .PC_W           (PW)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_sw_step   (sw_step),
    .i_mode      (mode),
    .i_burst_len (burst_len),
    .i_run_div   (run_div),
    .i_pc        (pc),
    .i_bp_addr   (bp_addr),
    .i_bp_valid  (bp_valid),
    .o_cpu_en    (cpu_en),
    .o_busy      (busy),
    .o_halted    (halted),
    .o_step_count(step_count)
  );

  typedef struct {
    int unsigned   cyc;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          sb_q[$];
  int unsigned   n_cmp = 0;
  int unsigned   n_bad = 0;
  int unsigned   cyc_n = 0;
  int unsigned   n;
  logic [CW-1:0] mc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int unsigned c, input logic [CW-1:0] v);
    exp_t e;
    e.cyc = c;
    e.cnt = v;
    sb_q.push_back(e);
  endtask

  // One cycle: sample on the falling edge, score any enable, advance the modelled PC.
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    cyc_n++;
    if (cpu_en === 1'b1) begin
      pc = pc + 32'd4;
      e.cyc = 0;
      e.cnt = '0;
      if (sb_q.size() > 0) e = sb_q.pop_front();
      chk("en_cycle", cyc_n, e.cyc);
      chk("en_count", 32'(step_count), 32'(e.cnt));
    end
  endtask

  task automatic wait_n(input int unsigned k);
    repeat (k) cyc();
  endtask

  task automatic press(input int unsigned hold);
    sw_step = 1'b1;
    wait_n(hold);
    sw_step = 1'b0;
  endtask

  task automatic drain(input string tag);
    chk(tag, 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  // Free-run start/stop with run_div=0: enables at n+9 .. n+27.
  task automatic run_19();
    n = cyc_n;
    for (int k = 0; k < 19; k++) push(n + 9 + k, mc + CW'(k + 1));
    mc = mc + CW'(19);
    press(10);
    wait_n(10);
    press(10);
    wait_n(15);
  endtask

  initial begin
    reset     = 1'b1;
    sw_step   = 1'b0;
    mode      = 2'b00;
    burst_len = '0;
    run_div   = '0;
    pc        = '0;
    bp_addr   = '0;
    bp_valid  = 1'b0;
    wait_n(3);
    chk("rst_cpu_en", 32'(cpu_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_count", 32'(step_count), 32'd0);
    reset = 1'b0;
    mc    = '0;
    wait_n(2);

    // Single step with a long hold, then a glitch, then mode 11.
    n  = cyc_n;
    mc = mc + CW'(1);
    push(n + 8, mc);
    press(20);
    wait_n(12);
    drain("s1_missing");
    chk("s1_count", 32'(step_count), 32'd1);
    press(2);
    wait_n(12);
    chk("glitch_count", 32'(step_count), 32'd1);
    mode = 2'b11;
    n    = cyc_n;
    mc   = mc + CW'(1);
    push(n + 8, mc);
    press(10);
    wait_n(12);
    drain("mode11_missing");
    chk("mode11_count", 32'(step_count), 32'd2);

    // Burst of 5; later input changes must be ignored.
    mode      = 2'b01;
    burst_len = 8'd5;
    n         = cyc_n;
    for (int k = 0; k < 5; k++) push(n + 9 + k, mc + CW'(k + 1));
    mc = mc + CW'(5);
    press(10);
    chk("burst_busy", 32'(busy), 32'd1);
    burst_len = 8'd9;
    mode      = 2'b00;
    wait_n(15);
    chk("burst_idle", 32'(busy), 32'd0);
    drain("burst_missing");
    chk("burst_count", 32'(step_count), 32'd7);
    mode      = 2'b01;
    burst_len = 8'd0;
    n         = cyc_n;
    mc        = mc + CW'(1);
    push(n + 9, mc);
    press(10);
    wait_n(15);
    drain("burst0_missing");
    chk("burst0_count", 32'(step_count), 32'd8);

    // Free-run divided by 4, aborted by a second press.
    mode    = 2'b10;
    run_div = 24'd3;
    n       = cyc_n;
    for (int k = 0; k < 5; k++) push(n + 9 + 4 * k, mc + CW'(k + 1));
    mc = mc + CW'(5);
    press(10);
    run_div = 24'd0;
    wait_n(10);
    press(10);
    chk("run_abort_busy", 32'(busy), 32'd0);
    wait_n(15);
    drain("run4_missing");
    chk("run4_count", 32'(step_count), 32'd13);
    run_19();
    drain("run1_missing");
    chk("run1_count", 32'(step_count), 32'd32);

    // Breakpoint at 0x18 with pc advancing 4 per enable from 0.
    pc       = '0;
    bp_addr  = 32'h18;
    bp_valid = 1'b1;
`ifdef CPU_STEP_BREAKPOINT_EN
    n = cyc_n;
    for (int k = 0; k < 6; k++) push(n + 9 + k, mc + CW'(k + 1));
    mc = mc + CW'(6);
    press(10);
    wait_n(10);
    chk("bp_halted", 32'(halted), 32'd1);
    chk("bp_pc", pc, 32'h18);
    chk("bp_busy", 32'(busy), 32'd0);
    chk("bp_cpu_en", 32'(cpu_en), 32'd0);
    press(10);
    wait_n(15);
    chk("bp_release", 32'(halted), 32'd0);
    drain("bp_missing");
    run_19();
    drain("bp_resume_missing");
    chk("bp_resume_pc", pc, 32'h64);
    chk("bp_resume_halted", 32'(halted), 32'd0);
    chk("bp_count", 32'(step_count), 32'd57);
`else
    run_19();
    drain("nobp_missing");
    chk("nobp_halted", 32'(halted), 32'd0);
    chk("nobp_pc", pc, 32'h4c);
    chk("nobp_count", 32'(step_count), 32'd51);
`endif
    bp_valid = 1'b0;

    // Reset in the middle of a burst, after two of five enables.
    mode      = 2'b01;
    burst_len = 8'd5;
    n         = cyc_n;
    push(n + 9, mc + CW'(1));
    push(n + 10, mc + CW'(2));
    press(10);
    reset = 1'b1;
    cyc();
    chk("midrst_cpu_en", 32'(cpu_en), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_count", 32'(step_count), 32'd0);
    drain("midrst_missing");
    reset = 1'b0;
    mc    = '0;
    wait_n(15);
    drain("midrst_quiet");
    chk("midrst_still0", 32'(step_count), 32'd0);

    // 65537 enables from zero: passes 0xFFFF and wraps to 0x0000, ending at 1.
    mode    = 2'b10;
    run_div = 24'd0;
    n       = cyc_n;
    for (int k = 0; k < 65537; k++) push(n + 9 + k, mc + CW'(k + 1));
    press(10);
    wait_n(65528);
    press(10);
    wait_n(15);
    drain("wrap_missing");
    chk("wrap_count", 32'(step_count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
